// File: rtl/bus_sequencer.sv
// Fetch/decode/execute sequencer driving accumulator-bus strobes; optional JZ via `SEQ_JZ_EN.
// Latency: 3 cycles per instruction, all outputs registered (strobes live for the EXECUTE cycle only).
// Backpressure: RUN low holds FETCH with IR/PC frozen; HALT is left only through RST.
module bus_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic [7:0]        INSTR,
  input  logic [3:0]        ACCA,
  output logic [ADDR_W-1:0] PC,
  output logic              LOADA,
  output logic              LOADB,
  output logic              ENABLEINSTR,
  output logic              ENABLEALU,
  output logic [3:0]        DATA,
  output logic [1:0]        ALUOP,
  output logic              OUTEN,
  output logic              HALTED
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state_q, state_d;
  logic [7:0]          ir_q, ir_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                loada_q, loada_d;
  logic                loadb_q, loadb_d;
  logic                en_instr_q, en_instr_d;
  logic                en_alu_q, en_alu_d;
  logic [3:0]          data_q, data_d;
  logic [1:0]          aluop_q, aluop_d;
  logic                outen_q, outen_d;
  logic                halted_q, halted_d;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   jump_tgt;

  assign opcode   = ir_q[7:4];
  assign jump_tgt = ADDR_W'(ir_q[3:0]);

`ifndef SEQ_JZ_EN
  logic unused_acca;
  assign unused_acca = ^ACCA;
`endif

  // Strobes default low so they can only be high for the single cycle after DECODE.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    data_d     = data_q;
    aluop_d    = aluop_q;
    halted_d   = halted_q;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    en_instr_d = 1'b0;
    en_alu_d   = 1'b0;
    outen_d    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (RUN) begin
          ir_d    = INSTR;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        pc_d   = pc_q + 1'b1;
        data_d = ir_q[3:0];
        if (opcode == OP_HLT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
          case (opcode)
            OP_LDA: begin
              loada_d    = 1'b1;
              en_instr_d = 1'b1;
            end
            OP_LDB: begin
              loadb_d    = 1'b1;
              en_instr_d = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              loada_d  = 1'b1;
              en_alu_d = 1'b1;
              aluop_d  = 2'(opcode - OP_ADD);
            end
            OP_OUT:  outen_d = 1'b1;
            default: ;
          endcase
        end
      end

      S_EXECUTE: begin
        state_d = S_FETCH;
        if (opcode == OP_JMP) begin
          pc_d = jump_tgt;
        end
`ifdef SEQ_JZ_EN
        if (opcode == OP_JZ && ACCA == 4'd0) begin
          pc_d = jump_tgt;
        end
`else
        if (opcode == OP_JZ) begin
          pc_d = pc_q;
        end
`endif
      end

      S_HALT: begin
        halted_d = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      pc_q       <= '0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      en_instr_q <= 1'b0;
      en_alu_q   <= 1'b0;
      data_q     <= '0;
      aluop_q    <= 2'b00;
      outen_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      en_instr_q <= en_instr_d;
      en_alu_q   <= en_alu_d;
      data_q     <= data_d;
      aluop_q    <= aluop_d;
      outen_q    <= outen_d;
      halted_q   <= halted_d;
    end
  end

  assign PC          = pc_q;
  assign LOADA       = loada_q;
  assign LOADB       = loadb_q;
  assign ENABLEINSTR = en_instr_q;
  assign ENABLEALU   = en_alu_q;
  assign DATA        = data_q;
  assign ALUOP       = aluop_q;
  assign OUTEN       = outen_q;
  assign HALTED      = halted_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed table-driven bench for bus_sequencer plus a program-memory driven run to HALT.
module tb_bus_sequencer;
  localparam int ADDR_W = 4;
`ifdef SEQ_JZ_EN
  localparam bit JZ_ON = 1'b1;
`else
  localparam bit JZ_ON = 1'b0;
`endif

  // Strobe vector order: {LOADA, LOADB, ENABLEINSTR, ENABLEALU, OUTEN, HALTED}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LDA  = 6'b101000;
  localparam logic [5:0] S_LDB  = 6'b011000;
  localparam logic [5:0] S_ALU  = 6'b100100;
  localparam logic [5:0] S_OUT  = 6'b000010;
  localparam logic [5:0] S_HLT  = 6'b000001;

  logic              clk = 1'b0;
  logic              rst, run;
  logic [7:0]        instr;
  logic [3:0]        acca;
  logic [ADDR_W-1:0] pc;
  logic              loada, loadb, en_instr, en_alu, outen, halted;
  logic [3:0]        data;
  logic [1:0]        aluop;

  bus_sequencer #(.ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst), .RUN(run), .INSTR(instr), .ACCA(acca),
    .PC(pc), .LOADA(loada), .LOADB(loadb), .ENABLEINSTR(en_instr),
    .ENABLEALU(en_alu), .DATA(data), .ALUOP(aluop), .OUTEN(outen), .HALTED(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       run;
    logic [7:0] instr;
    logic [3:0] acca;
    logic [3:0] pc;
    logic [5:0] stb;
    logic [3:0] data;
    logic [1:0] op;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic row(input logic r, input logic rn, input logic [7:0] i, input logic [3:0] a,
                     input logic [3:0] p, input logic [5:0] s, input logic [3:0] d, input logic [1:0] o);
    vec_t v;
    v.rst = r; v.run = rn; v.instr = i; v.acca = a;
    v.pc = p; v.stb = s; v.data = d; v.op = o;
    vecs.push_back(v);
  endtask

  // One instruction = fetch, decode, execute edges; acca_x is applied on the execute edge.
  task automatic ins(input logic [7:0] i, input logic [3:0] acca_x, input logic [3:0] pc0,
                     input logic [3:0] pc_exec, input logic [5:0] s, input logic [3:0] d0,
                     input logic [1:0] op0, input logic [1:0] op1);
    logic [3:0] pc1;
    pc1 = 4'(pc0 + 4'd1);
    row(1'b0, 1'b1, i, 4'd4,   pc0,     S_NONE, d0,     op0);
    row(1'b0, 1'b1, i, 4'd4,   pc1,     s,      i[3:0], op1);
    row(1'b0, 1'b1, i, acca_x, pc_exec, S_NONE, i[3:0], op1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [3:0] p, q;
  logic [7:0] mem [16];
  int         n_loada, n_outen, n_clash, hcyc;

  initial begin
    rst = 1'b1; run = 1'b1; instr = 8'h1A; acca = 4'd4;

    // Reset with LDA 0xA pending, then first instruction after release.
    row(1, 1, 8'h1A, 4, 0, S_NONE, 0, 0);
    row(1, 1, 8'h1A, 4, 0, S_NONE, 0, 0);
    ins(8'h1A, 4, 0, 1, S_LDA, 0, 0, 0);
    // Reset again, then LDA 3 / LDB 5 / ADD / OUT / OR.
    row(1, 1, 8'h13, 4, 0, S_NONE, 0, 0);
    ins(8'h13, 4, 0, 1, S_LDA, 0, 0, 0);
    ins(8'h25, 4, 1, 2, S_LDB, 3, 0, 0);
    ins(8'h30, 4, 2, 3, S_ALU, 5, 0, 0);
    ins(8'h70, 4, 3, 4, S_OUT, 0, 0, 0);
    ins(8'h60, 4, 4, 5, S_ALU, 0, 0, 3);
    // RUN low for 5 cycles in FETCH: everything frozen.
    for (int k = 0; k < 5; k++) row(0, 0, 8'hAB, 4, 5, S_NONE, 0, 3);
    ins(8'h41, 4, 5, 6, S_ALU, 0, 3, 1);
    ins(8'h0C, 4, 6, 7, S_NONE, 1, 1, 1);
    ins(8'hBE, 4, 7, 8, S_NONE, 4'hC, 1, 1);
    ins(8'h8F, 4, 8, 15, S_NONE, 4'hE, 1, 1);
    // JMP 2 at PC=15: wraps to 0 in DECODE, lands on 2 after EXECUTE.
    ins(8'h82, 4, 15, 2, S_NONE, 4'hF, 1, 1);
    p = JZ_ON ? 4'd7 : 4'd3;
    ins(8'h97, 0, 2, p, S_NONE, 2, 1, 1);
    q = 4'(p + 4'd1);
    ins(8'h97, 4, p, q, S_NONE, 7, 1, 1);
    // HLT, then stays halted with RUN high until RST.
    row(0, 1, 8'hF0, 4, q, S_NONE, 7, 1);
    row(0, 1, 8'hF0, 4, 4'(q + 4'd1), S_HLT, 0, 1);
    for (int k = 0; k < 3; k++) row(0, 1, 8'h13, 4, 4'(q + 4'd1), S_HLT, 0, 1);
    row(1, 1, 8'h45, 4, 0, S_NONE, 0, 0);
    // RST during EXECUTE of SUB clears strobes on that edge.
    row(0, 1, 8'h45, 4, 0, S_NONE, 0, 0);
    row(0, 1, 8'h45, 4, 1, S_ALU, 5, 1);
    row(1, 1, 8'h45, 4, 0, S_NONE, 0, 0);
    row(0, 0, 8'h45, 4, 0, S_NONE, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst = vecs[k].rst; run = vecs[k].run; instr = vecs[k].instr; acca = vecs[k].acca;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d {pc,stb,data,op}", k),
          {16'd0, pc, loada, loadb, en_instr, en_alu, outen, halted, data, aluop},
          {16'd0, vecs[k].pc, vecs[k].stb, vecs[k].data, vecs[k].op});
    end

    // Program-memory driven run: LDA 3, ADD, OUT, HLT.
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    mem[0] = 8'h13; mem[1] = 8'h30; mem[2] = 8'h70; mem[3] = 8'hF0;
    @(negedge clk);
    rst = 1'b1; run = 1'b1; acca = 4'd4;
    @(posedge clk);
    #1;
    n_loada = 0; n_outen = 0; n_clash = 0; hcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      rst = 1'b0;
      instr = mem[pc];
      @(posedge clk);
      #1;
      if (loada) n_loada++;
      if (outen) n_outen++;
      if ((en_instr && en_alu) || (loadb && en_alu)) n_clash++;
      if (halted) begin
        hcyc = c;
        break;
      end
    end
    chk("halt_cycle", hcyc, 11);
    chk("prog_pc", 32'(pc), 4);
    chk("prog_loada_count", n_loada, 2);
    chk("prog_outen_count", n_outen, 1);
    chk("prog_bus_clash", n_clash, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
